mem_port_arbiter: RTL

Shares the single-port 8-bit image RAM (16-bit address, input image at 0x0000, output image at 0x4000) between up to N_REQ requesters. Defaults: 0 = processing engine (sequential/SIMD fetch-and-write FSM), 1 = host loader, 2 = debug readback. The arbitration policy is round-robin, with an optional bounded lock for fetch bursts. The block sits between the requesters and the RAM, registers the RAM command, and routes read data back to the issuing requester using a latency-tracking tag pipe.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/mem_port_arbiter_rr_picker.sv | 31 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the image-RAM port arbiter.
// Image layout: input image at IN_BASE, output image at OUT_BASE.
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 8;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] pix_t;

    localparam mem_addr_t IN_BASE  = 16'h0000;
    localparam mem_addr_t OUT_BASE = 16'h4000;

    localparam int REQ_ENGINE = 0;
    localparam int REQ_HOST   = 1;
    localparam int REQ_DEBUG  = 2;

    // Wide enough for up to 8 requesters.
    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the image-RAM arbiter: per-requester command
// inputs, one-hot grant/read-valid and the broadcast read data.
interface mem_port_arbiter_if #(parameter int N_REQ = 3);
    import mem_port_arbiter_pkg::*;

    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      lock;
    logic [N_REQ-1:0]      we;
    mem_addr_t [N_REQ-1:0] addr;
    pix_t [N_REQ-1:0]      wdata;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      rvalid;
    pix_t                  rdata;

    modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: first eligible requester after ptr, modulo N_REQ.
// The exclude mask is only honoured when some other requester is asking.
module rr_picker #(
    parameter  int N_REQ = 3,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] gnt
);

    logic [N_REQ-1:0] eligible;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        eligible = ((req & ~exclude) != '0) ? (req & ~exclude) : req;
        gnt      = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && eligible[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port image RAM between N_REQ requesters, with
// bounded burst lock, registered RAM command and tag-tracked read return.
//
// state   | meaning
// LK_FREE | no burst owner; grant follows round-robin from ptr
// LK_HELD | owner keeps the grant while it keeps requesting
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int READ_LAT = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic                mem_en,
    output logic                mem_we,
    output mem_addr_t           mem_addr,
    output pix_t                mem_wdata,
    input  pix_t                mem_rdata,
    output logic                busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    lock_state_t      state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] count_q, count_d, base;
    logic             excl_q, excl_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] gnt, rr_gnt, excl_mask;
    logic             accept;
    logic [IDX_W-1:0] acc_idx;

    rd_tag_t          pipe [READ_LAT+1];
    rd_tag_t          tail;
    logic             in_flight;
    pix_t             rdata_q;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .exclude (excl_mask),
        .gnt     (rr_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LK_FREE;
            owner_q <= '0;
            count_q <= '0;
            excl_q  <= 1'b0;
            ptr_q   <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
            excl_q  <= excl_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        accept  = |(bus.req & gnt);
        acc_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) acc_idx = IDX_W'(i);
        end
    end

    // Count only runs on while the same owner keeps accepting; the accept
    // that hits the cap releases the lock and parks the owner for one contest.
    always_comb begin
        state_d = LK_FREE;
        owner_d = owner_q;
        count_d = '0;
        excl_d  = 1'b0;
        ptr_d   = ptr_q;
        base    = (state_q == LK_HELD && owner_q == acc_idx) ? count_q : '0;
        if (accept) begin
            ptr_d   = acc_idx;
            owner_d = acc_idx;
            if (bus.lock[acc_idx]) begin
                if (base < CNT_W'(MAX_LOCK - 1)) begin
                    state_d = LK_HELD;
                    count_d = base + CNT_W'(1);
                end else begin
                    excl_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        excl_mask = excl_q ? (N_REQ'(1) << owner_q) : '0;
        if (state_q == LK_HELD && bus.req[owner_q]) begin
            gnt = N_REQ'(1) << owner_q;
        end else begin
            gnt = rr_gnt;
        end
        bus.gnt = gnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            for (int s = 0; s <= READ_LAT; s++) pipe[s] <= '0;
        end else begin
            mem_en <= accept;
            mem_we <= accept & bus.we[acc_idx];
            if (accept) begin
                mem_addr  <= bus.addr[acc_idx];
                mem_wdata <= bus.wdata[acc_idx];
            end
            pipe[0] <= '{valid: accept & ~bus.we[acc_idx], idx: TAG_IDX_W'(acc_idx)};
            for (int s = 1; s <= READ_LAT; s++) pipe[s] <= pipe[s-1];
            if (tail.valid) rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        tail      = pipe[READ_LAT];
        in_flight = 1'b0;
        for (int s = 0; s <= READ_LAT; s++) in_flight = in_flight | pipe[s].valid;
        for (int i = 0; i < N_REQ; i++) begin
            bus.rvalid[i] = tail.valid && (tail.idx == TAG_IDX_W'(i));
        end
        bus.rdata = tail.valid ? mem_rdata : rdata_q;
        busy      = in_flight | accept;
    end

endmodule
